fmul_arb: RTL and testbench
===========================

Name: fmul_arb

Overview:
- Round-robin arbiter and sequencer that shares one fmul unit among NREQ requesters, such as FPU issue ports or a vector lane scheduler.
- Accepts one operand pair at a time and holds the operands stable on the fmul inputs for the whole operation, as fmul requires.
- Drives the fmul ready/valid start-done handshake, captures the product, and returns it to the owning requester.
- One operation in flight. fmul is instantiated outside this block, at the parent level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WDOG, 6, cycles after issue with no fmul_valid before err_timeout sets.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot accept strobe.
- req_x1  in  32*NREQ  operand 1, slice i for requester i.
- req_x2  in  32*NREQ  operand 2, slice i for requester i.
- resp_valid  out  NREQ  one-hot result valid.
- resp_ready  in  NREQ  per-requester result accept.
- resp_y  out  32  product for the requester flagged in resp_valid.
- fmul_x1  out  32  to fmul x1, held from accept until capture.
- fmul_x2  out  32  to fmul x2, held from accept until capture.
- fmul_ready  out  1  to fmul ready, single-cycle start pulse.
- fmul_valid  in  1  from fmul valid.
- fmul_y  in  32  from fmul y.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, active-high): all outputs go low or zero; state=IDLE; rr_ptr=NREQ-1; operand, result and owner registers cleared. The parent drives fmul rstn = ~rst, so both blocks leave reset together.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from rr_ptr+1, wrapping modulo NREQ.
  - Same cycle: req_ready[winner]=1, which completes the transfer. Latch the winner's x1/x2 into the operand registers, owner=winner, rr_ptr=winner. Go to ISSUE.
  - With no request: stay in IDLE. req_ready is never asserted outside IDLE.
- ISSUE: fmul_ready=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - fmul_ready=0.
  - On fmul_valid: capture fmul_y into the result register and go to RESP.
  - Nominal: fmul_valid arrives in the second cycle after ISSUE.
  - Otherwise increment the watchdog counter. When it reaches WDOG, set err_timeout (sticky until rst) and go to RESP with the result forced to 0x7FC00000.
- RESP:
  - resp_valid[owner]=1 and resp_y=result, both held stable until resp_ready[owner].
  - In the cycle resp_ready[owner] is seen, return to IDLE. resp_ready of other requesters is ignored.
- fmul_x1/fmul_x2 always come from the operand registers; they change only on an IDLE accept.
- Latency: accept in cycle T, ISSUE in T+1, fmul_valid in T+3, resp_valid from T+4. Minimum 5 cycles per operation with resp_ready tied high.
- Fairness: a requester holding req_valid is served within NREQ grants.
- req_valid may drop before acceptance; no request is remembered.
- Simultaneous requests: resolved only in IDLE by round-robin. Requests arriving in other states wait.
- rst asserted mid-operation: return to IDLE immediately and discard the in-flight result; no resp_valid is produced for it.
- The fmul result is passed through unmodified: sign = XOR of signs, zero-exponent inputs flush to zero.

Decomposition:
- Package fmul_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - localparam FMUL_LAT=2 (cycles from the ISSUE edge to fmul_valid);
  - localparam QNAN=32'h7FC00000.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and rr_ptr; outputs are a one-hot grant and a found bit.

Test Plan:
- Single op: req 0 sends x1=0x3FC00000 (1.5), x2=0x40000000 (2.0) -> req_ready[0] in cycle T, fmul_ready at T+1, resp_valid[0] at T+4, resp_y=0x40400000.
- Sign and zero: 0xC0000000 x 0x3F000000 -> 0xBF800000; 0x00000000 x 0x40400000 -> 0x00000000.
- Contention: all 4 req_valid held high from reset -> grant order 0,1,2,3,0; each result is routed only to its owner's resp_valid bit.
- Backpressure: resp_ready[1] held low for 10 cycles -> resp_valid[1] and resp_y stay stable, no new accept, fmul_x1/fmul_x2 unchanged.
- Watchdog: fmul_valid tied low -> err_timeout rises 6 cycles after ISSUE; resp_y=0x7FC00000; err_timeout stays high until rst.
- Reset mid-WAIT: rst pulse -> busy=0, no resp_valid for the discarded op; a new request afterwards completes normally.

Source files
------------

// File: rtl/fmul_arb_pkg.sv
// Shared types and constants for the fmul round-robin arbiter.
package fmul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Cycles from the ISSUE edge until fmul raises valid.
    localparam int FMUL_LAT = 2;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fmul_arb_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            found
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmul_arb.sv
// Shares one external fmul among NREQ requesters; one operation in flight,
// operands held on the fmul inputs from accept until the result is captured.
//
//   state | meaning
//   IDLE  | waiting for any req_valid; round-robin accept happens here
//   ISSUE | one-cycle fmul_ready start pulse, watchdog loaded
//   WAIT  | waiting for fmul_valid or watchdog expiry
//   RESP  | result presented to owner until its resp_ready
module fmul_arb
    import fmul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WDOG = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_y,
    output logic [31:0]          fmul_x1,
    output logic [31:0]          fmul_x2,
    output logic                 fmul_ready,
    input  logic                 fmul_valid,
    input  logic [31:0]          fmul_y,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Never let the watchdog expire before a nominal fmul response.
    localparam int WDOG_EFF = (WDOG > FMUL_LAT) ? WDOG : FMUL_LAT + 1;
    localparam int CW = $clog2(WDOG_EFF + 1);

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   grant;
    logic              found;
    logic [31:0]       op_x1;
    logic [31:0]       op_x2;
    logic [31:0]       sel_x1;
    logic [31:0]       sel_x2;
    logic [31:0]       result;
    logic [CW-1:0]     wdog_cnt;
    logic [NREQ-1:0]   owner_hot;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        win_idx = '0;
        sel_x1  = '0;
        sel_x2  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
                sel_x1  = req_x1[i*32 +: 32];
                sel_x2  = req_x2[i*32 +: 32];
            end
        end
    end

    assign owner_hot = {{(NREQ-1){1'b0}}, 1'b1} << owner;

    // The accept strobe must complete the transfer in the same cycle.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign fmul_x1   = op_x1;
    assign fmul_x2   = op_x2;
    assign resp_y    = result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= PW'(NREQ - 1);
            owner       <= '0;
            op_x1       <= '0;
            op_x2       <= '0;
            result      <= '0;
            wdog_cnt    <= '0;
            fmul_ready  <= 1'b0;
            resp_valid  <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_x1      <= sel_x1;
                        op_x2      <= sel_x2;
                        owner      <= win_idx;
                        rr_ptr     <= win_idx;
                        fmul_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    fmul_ready <= 1'b0;
                    wdog_cnt   <= CW'(WDOG_EFF - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (fmul_valid) begin
                        result     <= fmul_y;
                        resp_valid <= owner_hot;
                        state      <= RESP;
                    end else if (wdog_cnt == CW'(1)) begin
                        err_timeout <= 1'b1;
                        result      <= QNAN;
                        resp_valid  <= owner_hot;
                        state       <= RESP;
                    end else begin
                        wdog_cnt <= wdog_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_arb.sv
// Bench for fmul_arb: behavioural fmul peer plus a round-robin reference model.
module tb_fmul_arb;

    localparam int NREQ = 4;
    localparam logic [31:0] NAN_Y = 32'h7FC0_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_x1;
    logic [32*NREQ-1:0]  req_x2;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [31:0]         resp_y;
    logic [31:0]         fmul_x1;
    logic [31:0]         fmul_x2;
    logic                fmul_ready;
    logic                fmul_valid;
    logic [31:0]         fmul_y;
    logic                busy;
    logic                err_timeout;

    logic                fmul_en;
    logic                fm_d1;
    int                  total = 0;
    int                  bad = 0;

    always #5 clk = ~clk;

    fmul_arb #(.NREQ(NREQ), .WDOG(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x1      (req_x1),
        .req_x2      (req_x2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_y      (resp_y),
        .fmul_x1     (fmul_x1),
        .fmul_x2     (fmul_x2),
        .fmul_ready  (fmul_ready),
        .fmul_valid  (fmul_valid),
        .fmul_y      (fmul_y),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // Truncating single-precision multiply, zero exponents flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'b0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (m[47]) begin
            e = e + 1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    // fmul peer: result valid two cycles after the start pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fm_d1      <= 1'b0;
            fmul_valid <= 1'b0;
            fmul_y     <= '0;
        end else begin
            fm_d1      <= fmul_ready & fmul_en;
            fmul_valid <= fm_d1;
            fmul_y     <= fm_d1 ? fp_mul(fmul_x1, fmul_x2) : 32'h0;
        end
    end

    task automatic put_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_x1[i*32 +: 32] = a;
        req_x2[i*32 +: 32] = b;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req_valid  = '0;
        resp_ready = '0;
        req_x1     = '0;
        req_x2     = '0;
        fmul_en    = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({busy, fmul_ready, err_timeout, req_ready, resp_valid} !== '0) begin
            bad++;
            $display("FAIL reset_ctl: got busy=%b fr=%b err=%b rr=%b rv=%b want all 0",
                     busy, fmul_ready, err_timeout, req_ready, resp_valid);
        end
        total++;
        if ({resp_y, fmul_x1, fmul_x2} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: got y=%h x1=%h x2=%h want 0", resp_y, fmul_x1, fmul_x2);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        put_ops(0, 32'h3FC0_0000, 32'h4000_0000);
        resp_ready = '1;
        req_valid  = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_accept: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if (fmul_ready !== 1'b1 || fmul_x1 !== 32'h3FC0_0000 || fmul_x2 !== 32'h4000_0000) begin
            bad++;
            $display("FAIL single_issue: got fr=%b x1=%h x2=%h want 1 3fc00000 40000000", fmul_ready, fmul_x1, fmul_x2);
        end
        @(negedge clk);
        #1;
        total++;
        if (fmul_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait: got fr=%b busy=%b want 0 1", fmul_ready, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (resp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_resp: got %b want 0000", resp_valid); end
        @(negedge clk);
        #1;
        total++;
        if (resp_valid !== 4'b0001 || resp_y !== 32'h4040_0000) begin
            bad++;
            $display("FAIL single_resp: got rv=%b y=%h want 0001 40400000", resp_valid, resp_y);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL single_done: got busy=%b rv=%b want 0 0000", busy, resp_valid);
        end
    endtask

    task automatic test_sign_zero;
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] vy [2];
        int n;
        va[0] = 32'hC000_0000; vb[0] = 32'h3F00_0000; vy[0] = 32'hBF80_0000;
        va[1] = 32'h0000_0000; vb[1] = 32'h4040_0000; vy[1] = 32'h0000_0000;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            put_ops(v + 1, va[v], vb[v]);
            req_valid = 4'(1) << (v + 1);
            #1;
            total++;
            if (req_ready !== (4'(1) << (v + 1))) begin
                bad++;
                $display("FAIL signzero_accept%0d: got %b want %b", v, req_ready, 4'(1) << (v + 1));
            end
            @(negedge clk);
            req_valid = '0;
            n = 0;
            while (resp_valid === '0 && n < 12) begin @(negedge clk); #1; n++; end
            total++;
            if (resp_valid !== (4'(1) << (v + 1)) || resp_y !== vy[v]) begin
                bad++;
                $display("FAIL signzero_resp%0d: got rv=%b y=%h want %b %h", v, resp_valid, resp_y, 4'(1) << (v + 1), vy[v]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_contention;
        int n, w;
        do_reset();
        for (int i = 0; i < NREQ; i++) put_ops(i, $urandom, $urandom);
        resp_ready = '1;
        req_valid  = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            w = g % NREQ;
            n = 0;
            while (req_ready === '0 && n < 20) begin @(negedge clk); #1; n++; end
            total++;
            if (req_ready !== (4'(1) << w)) begin
                bad++;
                $display("FAIL contention_grant%0d: got %b want %b", g, req_ready, 4'(1) << w);
            end
            n = 0;
            while (resp_valid === '0 && n < 20) begin @(negedge clk); #1; n++; end
            total++;
            if (resp_valid !== (4'(1) << w) || resp_y !== fp_mul(req_x1[w*32 +: 32], req_x2[w*32 +: 32])) begin
                bad++;
                $display("FAIL contention_resp%0d: got rv=%b y=%h want %b %h", g, resp_valid, resp_y,
                         4'(1) << w, fp_mul(req_x1[w*32 +: 32], req_x2[w*32 +: 32]));
            end
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        put_ops(1, 32'h3FC0_0000, 32'h4040_0000);
        put_ops(3, 32'h4000_0000, 32'h4000_0000);
        resp_ready = 4'b1101;
        req_valid  = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        n = 0;
        while (resp_valid === '0 && n < 12) begin @(negedge clk); #1; n++; end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (resp_valid !== 4'b0010 || resp_y !== 32'h4090_0000 || req_ready !== 4'b0000 ||
                fmul_x1 !== 32'h3FC0_0000 || fmul_x2 !== 32'h4040_0000) begin
                bad++;
                $display("FAIL bp_hold%0d: got rv=%b y=%h rr=%b x1=%h x2=%h want 0010 40900000 0000 3fc00000 40400000",
                         c, resp_valid, resp_y, req_ready, fmul_x1, fmul_x2);
            end
        end
        @(negedge clk);
        resp_ready = '1;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (resp_valid === '0 && n < 12) begin @(negedge clk); #1; n++; end
        total++;
        if (resp_valid !== 4'b1000 || resp_y !== 32'h4080_0000) begin
            bad++;
            $display("FAIL bp_next: got rv=%b y=%h want 1000 40800000", resp_valid, resp_y);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int          m_ptr, own, start, w;
        bit          outst, done;
        logic [31:0] ey, ex1;
        logic [NREQ-1:0] erv;
        do_reset();
        m_ptr = NREQ - 1;
        outst = 0;
        done  = 0;
        own   = 0;
        start = 0;
        ey    = '0;
        ex1   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (done) begin outst = 0; done = 0; end
            req_valid  = NREQ'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0) ? '1 : NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) put_ops(i, $urandom, $urandom);
            #1;
            if (!outst) begin
                total++;
                if (req_valid != '0) begin
                    w = -1;
                    for (int k = 1; k <= NREQ && w < 0; k++)
                        if (req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                    if (req_ready !== (4'(1) << w)) begin
                        bad++;
                        $display("FAIL rand_grant c%0d: got %b want %b", cyc, req_ready, 4'(1) << w);
                    end
                    outst = 1;
                    own   = w;
                    start = cyc;
                    m_ptr = w;
                    ex1   = req_x1[w*32 +: 32];
                    ey    = fp_mul(req_x1[w*32 +: 32], req_x2[w*32 +: 32]);
                end else if (req_ready !== '0) begin
                    bad++;
                    $display("FAIL rand_idle c%0d: got %b want 0000", cyc, req_ready);
                end
            end else begin
                erv = (cyc >= start + 4) ? (4'(1) << own) : '0;
                total++;
                if (resp_valid !== erv || req_ready !== '0 || fmul_x1 !== ex1) begin
                    bad++;
                    $display("FAIL rand_busy c%0d: got rv=%b rr=%b x1=%h want %b 0000 %h",
                             cyc, resp_valid, req_ready, fmul_x1, erv, ex1);
                end
                if (cyc >= start + 4) begin
                    total++;
                    if (resp_y !== ey) begin
                        bad++;
                        $display("FAIL rand_y c%0d: got %h want %h", cyc, resp_y, ey);
                    end
                    if (resp_ready[own]) done = 1;
                end
            end
        end
        @(negedge clk);
        req_valid  = '0;
        resp_ready = '1;
        for (int c = 0; c < 8; c++) @(negedge clk);
    endtask

    task automatic test_watchdog;
        int n;
        fmul_en = 1'b0;
        @(negedge clk);
        put_ops(2, 32'h3F80_0000, 32'h3F80_0000);
        resp_ready = '0;
        req_valid  = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL wd_accept: got %b want 0100", req_ready); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c == 1) begin
                total++;
                if (fmul_ready !== 1'b1) begin bad++; $display("FAIL wd_issue: got %b want 1", fmul_ready); end
            end
            if (c == 6) begin
                total++;
                if (err_timeout !== 1'b0 || resp_valid !== '0) begin
                    bad++;
                    $display("FAIL wd_early: got err=%b rv=%b want 0 0000", err_timeout, resp_valid);
                end
            end
            if (c == 7) begin
                total++;
                if (err_timeout !== 1'b1 || resp_valid !== 4'b0100 || resp_y !== NAN_Y) begin
                    bad++;
                    $display("FAIL wd_fire: got err=%b rv=%b y=%h want 1 0100 %h", err_timeout, resp_valid, resp_y, NAN_Y);
                end
            end
        end
        resp_ready = '1;
        fmul_en    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        put_ops(0, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (resp_valid === '0 && n < 12) begin @(negedge clk); #1; n++; end
        total++;
        if (resp_valid !== 4'b0001 || resp_y !== 32'h40C0_0000 || err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky: got rv=%b y=%h err=%b want 0001 40c00000 1", resp_valid, resp_y, err_timeout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int n;
        @(negedge clk);
        put_ops(3, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || fmul_ready !== 1'b0 || err_timeout !== 1'b0 || resp_valid !== '0) begin
            bad++;
            $display("FAIL rstmid_clear: got busy=%b fr=%b err=%b rv=%b want 0 0 0 0000",
                     busy, fmul_ready, err_timeout, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (resp_valid !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet%0d: got rv=%b busy=%b want 0000 0", c, resp_valid, busy);
            end
        end
        @(negedge clk);
        put_ops(2, 32'hC040_0000, 32'h4000_0000);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_accept: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (resp_valid === '0 && n < 12) begin @(negedge clk); #1; n++; end
        total++;
        if (resp_valid !== 4'b0100 || resp_y !== 32'hC0C0_0000) begin
            bad++;
            $display("FAIL rstmid_after: got rv=%b y=%h want 0100 c0c00000", resp_valid, resp_y);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL global_timeout: got no finish want finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_sign_zero();
        test_contention();
        test_backpressure();
        test_random();
        test_watchdog();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
